// File: rtl/riscv_pkg.sv
// Shared RV32 encoding constants, ALU op codes and encoder types.
// Used by the control path, the field packer and the encoder FSM.
package riscv_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_XOR   = 4'b0010;
  localparam logic [3:0] ALU_ADD   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0100;
  localparam logic [3:0] ALU_MUL   = 4'b0101;
  localparam logic [3:0] ALU_MULH  = 4'b0110;
  localparam logic [3:0] ALU_MULHU = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_SLT   = 4'b1100;
  localparam logic [3:0] ALU_SLTU  = 4'b1101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [2:0] {
    CMD_R     = 3'd0,
    CMD_I     = 3'd1,
    CMD_JAL   = 3'd2,
    CMD_JALR  = 3'd3,
    CMD_CSRRW = 3'd4,
    CMD_LI    = 3'd5
  } cmd_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_PEND  = 2'd2
  } enc_state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: command fields -> one or two RV32 words.
// Ports: cmd/aluop/rd/rs1/rs2/imm/csr in; word0, word1, two_words, illegal out.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  cmd,
  input  logic [3:0]  aluop,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  input  logic [11:0] csr,
  output logic [31:0] word0,
  output logic [31:0] word1,
  output logic        two_words,
  output logic        illegal
);

  logic [6:0]  r_f7;
  logic [2:0]  r_f3;
  logic        r_ok;
  logic [11:0] i_imm;
  logic [2:0]  i_f3;
  logic        i_ok;
  logic        shamt_ok;
  logic        jal_ok;
  logic        li_short;
  logic [19:0] lui_hi;

  assign shamt_ok = (imm[31:5] == 27'd0);
  // Signed 21-bit range means bits 31..20 all equal bit 20.
  assign jal_ok   = !imm[0] && ((imm[31:20] == 12'h000) ||
                                (imm[31:20] == 12'hfff));
  assign li_short = (imm[31:11] == 21'd0) ||
                    (imm[31:11] == 21'h1fffff);
  // Rounds up so the signed ADDI low part lands on the target.
  assign lui_hi   = imm[31:12] + {19'd0, imm[11]};

  always_comb begin
    r_f7 = F7_BASE;
    r_f3 = 3'b000;
    r_ok = 1'b1;
    case (aluop)
      ALU_ADD:   r_f3 = 3'b000;
      ALU_AND:   r_f3 = 3'b111;
      ALU_OR:    r_f3 = 3'b110;
      ALU_XOR:   r_f3 = 3'b100;
      ALU_SLL:   r_f3 = 3'b001;
      ALU_SRL:   r_f3 = 3'b101;
      ALU_SLT:   r_f3 = 3'b010;
      ALU_SLTU:  r_f3 = 3'b011;
      ALU_SUB:   r_f7 = F7_ALT;
      ALU_SRA: begin
        r_f7 = F7_ALT;
        r_f3 = 3'b101;
      end
      ALU_MUL:   r_f7 = F7_MUL;
      ALU_MULH: begin
        r_f7 = F7_MUL;
        r_f3 = 3'b001;
      end
      ALU_MULHU: begin
        r_f7 = F7_MUL;
        r_f3 = 3'b011;
      end
      default:   r_ok = 1'b0;
    endcase
  end

  always_comb begin
    i_imm = imm[11:0];
    i_f3  = 3'b000;
    i_ok  = 1'b1;
    case (aluop)
      ALU_ADD: i_f3 = 3'b000;
      ALU_AND: i_f3 = 3'b111;
      ALU_OR:  i_f3 = 3'b110;
      ALU_XOR: i_f3 = 3'b100;
      ALU_SLL: begin
        i_f3  = 3'b001;
        i_imm = {F7_BASE, imm[4:0]};
        i_ok  = shamt_ok;
      end
      ALU_SRL: begin
        i_f3  = 3'b101;
        i_imm = {F7_BASE, imm[4:0]};
        i_ok  = shamt_ok;
      end
      ALU_SRA: begin
        i_f3  = 3'b101;
        i_imm = {F7_ALT, imm[4:0]};
        i_ok  = shamt_ok;
      end
      default: i_ok = 1'b0;
    endcase
  end

  always_comb begin
    word0     = 32'd0;
    word1     = 32'd0;
    two_words = 1'b0;
    illegal   = 1'b0;
    case (cmd)
      CMD_R: begin
        word0   = {r_f7, rs2, rs1, r_f3, rd, OP_R};
        illegal = !r_ok;
      end
      CMD_I: begin
        word0   = {i_imm, rs1, i_f3, rd, OP_I};
        illegal = !i_ok;
      end
      CMD_JAL: begin
        word0   = {imm[20], imm[10:1], imm[11],
                   imm[19:12], rd, OP_JAL};
        illegal = !jal_ok;
      end
      CMD_JALR: begin
        word0 = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      end
      CMD_CSRRW: begin
        word0 = {csr, rs1, 3'b001, rd, OP_SYS};
      end
      CMD_LI: begin
        if (li_short) begin
          word0 = {imm[11:0], 5'd0, 3'b000, rd, OP_I};
        end else begin
          word0     = {lui_hi, rd, OP_LUI};
          word1     = {imm[11:0], rd, 3'b000, rd, OP_I};
          two_words = (imm[11:0] != 12'd0);
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Command-stream to RV32 word encoder with valid/ready on both sides.
// Ports: clk, rst, in_valid/in_ready + fields in; out_valid/out_ready, instr, err out.
module instr_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  cmd,
  input  logic [3:0]  aluop,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  input  logic [11:0] csr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err
);

  enc_state_t  state, state_n;
  logic [31:0] instr_n;
  logic [31:0] pend, pend_n;
  logic        err_n;
  logic [31:0] word0, word1;
  logic        two_words, illegal;
  logic        accept;

  instr_pack u_pack (
    .cmd       (cmd),
    .aluop     (aluop),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .csr       (csr),
    .word0     (word0),
    .word1     (word1),
    .two_words (two_words),
    .illegal   (illegal)
  );

  assign in_ready  = !rst &&
                     ((state == ST_EMPTY) ||
                      ((state == ST_FULL) && out_ready));
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_n = state;
    instr_n = instr;
    pend_n  = pend;
    err_n   = 1'b0;
    case (state)
      ST_EMPTY, ST_FULL: begin
        if (accept && illegal) begin
          err_n = 1'b1;
          if (state == ST_FULL) state_n = ST_EMPTY;
        end else if (accept) begin
          instr_n = word0;
          pend_n  = word1;
          state_n = two_words ? ST_PEND : ST_FULL;
        end else if (state == ST_FULL && out_ready) begin
          state_n = ST_EMPTY;
        end
      end
      ST_PEND: begin
        if (out_ready) begin
          instr_n = pend;
          state_n = ST_FULL;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
      instr <= 32'd0;
      pend  <= 32'd0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      instr <= instr_n;
      pend  <= pend_n;
      err   <= err_n;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
// Drives commands #1 after the rising edge and samples there too.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  cmd;
  logic [3:0]  aluop;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic [11:0] csr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cmd       (cmd),
    .aluop     (aluop),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .csr       (csr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .err       (err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] c,
                      input logic [3:0] op,
                      input logic [4:0] d,
                      input logic [4:0] s1,
                      input logic [4:0] s2,
                      input logic [31:0] im,
                      input logic [11:0] cs);
    in_valid = 1'b1;
    cmd      = c;
    aluop    = op;
    rd       = d;
    rs1      = s1;
    rs2      = s2;
    imm      = im;
    csr      = cs;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cmd       = 3'd0;
    aluop     = 4'd0;
    rd        = 5'd0;
    rs1       = 5'd0;
    rs2       = 5'd0;
    imm       = 32'd0;
    csr       = 12'd0;
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // add x3,x1,x2
    out_ready = 1'b1;
    send(3'd0, 4'b0011, 5'd3, 5'd1, 5'd2, 32'd0, 12'd0);
    tick();
    in_valid = 1'b0;
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_instr", instr, 32'h002081B3);
    chk("add_err", {31'd0, err}, 32'd0);
    tick();
    chk("add_drain", {31'd0, out_valid}, 32'd0);

    // addi x5,x0,-1 then csrrw x2,0x7c0,x1 back to back
    send(3'd1, 4'b0011, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 12'd0);
    tick();
    chk("addi_instr", instr, 32'hFFF00293);
    send(3'd4, 4'd0, 5'd2, 5'd1, 5'd0, 32'd0, 12'h7C0);
    #1;
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("csrrw_valid", {31'd0, out_valid}, 32'd1);
    chk("csrrw_instr", instr, 32'h7C009173);
    tick();
    chk("csrrw_drain", {31'd0, out_valid}, 32'd0);

    // li x1,0x12345fff with a 3-cycle stall
    out_ready = 1'b0;
    send(3'd5, 4'd0, 5'd1, 5'd0, 5'd0, 32'h12345FFF, 12'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("li_lui_stall", instr, 32'h123460B7);
      chk("li_valid_stall", {31'd0, out_valid}, 32'd1);
      chk("li_ready_stall", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("li_addi", instr, 32'hFFF08093);
    chk("li_addi_valid", {31'd0, out_valid}, 32'd1);
    tick();
    chk("li_empty", {31'd0, out_valid}, 32'd0);

    // li x1,0x7ff fits in one addi
    send(3'd5, 4'd0, 5'd1, 5'd0, 5'd0, 32'h0000_07FF, 12'd0);
    tick();
    in_valid = 1'b0;
    chk("li_short", instr, 32'h7FF00093);
    tick();
    chk("li_short_drain", {31'd0, out_valid}, 32'd0);

    // li x1,0x12345000 is a lone lui
    send(3'd5, 4'd0, 5'd1, 5'd0, 5'd0, 32'h12345000, 12'd0);
    tick();
    in_valid = 1'b0;
    chk("li_lui_only", instr, 32'h123450B7);
    tick();
    chk("li_lui_only_drain", {31'd0, out_valid}, 32'd0);

    // srai x1,x2,3
    send(3'd1, 4'b1010, 5'd1, 5'd2, 5'd0, 32'd3, 12'd0);
    tick();
    in_valid = 1'b0;
    chk("srai_instr", instr, 32'h40315093);
    tick();

    // jal x1,+8
    send(3'd2, 4'd0, 5'd1, 5'd0, 5'd0, 32'd8, 12'd0);
    tick();
    in_valid = 1'b0;
    chk("jal_instr", instr, 32'h008000EF);
    chk("jal_err", {31'd0, err}, 32'd0);
    tick();

    // jal with odd offset
    send(3'd2, 4'd0, 5'd1, 5'd0, 5'd0, 32'd7, 12'd0);
    tick();
    in_valid = 1'b0;
    chk("jal_odd_err", {31'd0, err}, 32'd1);
    chk("jal_odd_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("jal_odd_err_clr", {31'd0, err}, 32'd0);

    // jal just past the signed 21-bit range
    send(3'd2, 4'd0, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 12'd0);
    tick();
    in_valid = 1'b0;
    chk("jal_range_err", {31'd0, err}, 32'd1);
    chk("jal_range_valid", {31'd0, out_valid}, 32'd0);
    tick();

    // I-type sub, then cmd 6: two err pulses, no words
    send(3'd1, 4'b0100, 5'd1, 5'd1, 5'd0, 32'd1, 12'd0);
    tick();
    chk("isub_err", {31'd0, err}, 32'd1);
    chk("isub_valid", {31'd0, out_valid}, 32'd0);
    chk("isub_ready", {31'd0, in_ready}, 32'd1);
    send(3'd6, 4'd0, 5'd1, 5'd1, 5'd0, 32'd0, 12'd0);
    tick();
    in_valid = 1'b0;
    chk("cmd6_err", {31'd0, err}, 32'd1);
    chk("cmd6_valid", {31'd0, out_valid}, 32'd0);
    chk("cmd6_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("cmd6_err_clr", {31'd0, err}, 32'd0);

    // reset while holding lui with addi pending
    out_ready = 1'b0;
    send(3'd5, 4'd0, 5'd1, 5'd0, 5'd0, 32'h12345FFF, 12'd0);
    tick();
    in_valid = 1'b0;
    chk("pend_lui", instr, 32'h123460B7);
    rst = 1'b1;
    tick();
    chk("pend_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("pend_rst_instr", instr, 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("pend_dropped_1", {31'd0, out_valid}, 32'd0);
    tick();
    chk("pend_dropped_2", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
